// File: rtl/gray_disp_pkg.sv
// Shared constants and types for the Gray counter display block:
// default digit dwell, blank segment pattern, active-low hex font and
// the 2-bit digit-index type.
package gray_disp_pkg;

    localparam int DWELL_DEFAULT = 100000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low hex font, bit order gfedcba (seg[6]=g ... seg[0]=a).
    localparam logic [6:0] HEX_FONT [0:15] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

    typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/gray_counter_display_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to active-low 7-segment pattern.
module hex_to_7seg
    import gray_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Font lookup; the table already holds active-low patterns.
    always_comb begin
        seg_n = HEX_FONT[nibble];
    end

endmodule

// File: rtl/gray_counter_display.sv
// gray_counter_display: 8-bit up/down counter held as binary and Gray,
// shown on a 4-digit multiplexed common-anode 7-segment display
// (binary hex on digits 0/1, Gray hex on digits 2/3, dp marks digit 2).
// Optional build macro GRAY_COUNTER_SATURATE_EN: when defined the count
// saturates at 8'h00/8'hFF instead of wrapping.
module gray_counter_display
    import gray_disp_pkg::*;
#(
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_pulse,
    input  logic       down_pulse,
    output logic [7:0] bin,
    output logic [7:0] gray,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [19:0] SCAN_LAST = 20'(DWELL - 1);

    logic [7:0]  bin_q,  bin_d;
    logic [7:0]  gray_q, gray_d;
    logic [19:0] scan_q, scan_d;
    digit_idx_t  idx_q,  idx_d;
    logic [3:0]  an_q,   an_d;
    logic [6:0]  seg_q,  seg_d;
    logic        dp_q,   dp_d;

    logic [3:0]  nibble;
    logic [6:0]  font_seg;

    // Next count: step on a lone pulse, hold on both or neither.
    always_comb begin
        bin_d = bin_q;
        if (up_pulse && !down_pulse) begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (bin_q != 8'hFF) bin_d = bin_q + 8'd1;
`else
            bin_d = bin_q + 8'd1;
`endif
        end else if (down_pulse && !up_pulse) begin
`ifdef GRAY_COUNTER_SATURATE_EN
            if (bin_q != 8'h00) bin_d = bin_q - 8'd1;
`else
            bin_d = bin_q - 8'd1;
`endif
        end
        // Gray derived from the next binary so both registers move together.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Dwell counter and digit index; index advances when the dwell expires.
    always_comb begin
        scan_d = scan_q + 20'd1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = 20'd0;
            idx_d  = idx_q + 2'd1;
        end
    end

    // Nibble selection for the digit currently being scanned.
    always_comb begin
        nibble = bin_q[3:0];
        case (idx_q)
            2'd0:    nibble = bin_q[3:0];
            2'd1:    nibble = bin_q[7:4];
            2'd2:    nibble = gray_q[3:0];
            default: nibble = gray_q[7:4];
        endcase
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble (nibble),
        .seg_n  (font_seg)
    );

    // Display pin values for the current digit, registered next edge.
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = font_seg;
        dp_d  = (idx_q == 2'd2) ? 1'b0 : 1'b1;
    end

    // State registers; reset blanks the display and restarts the scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= 8'h00;
            gray_q <= 8'h00;
            scan_q <= 20'd0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;

endmodule

// File: tb/tb_gray_counter_display.sv
// Bench for gray_counter_display with DWELL=4: directed steps from the
// test plan plus a randomized tail, all checked against a cycle model
// built from plain counting arithmetic.
module tb_gray_counter_display;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up_pulse = 1'b0;
    logic       down_pulse = 1'b0;
    logic [7:0] bin;
    logic [7:0] gray;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int failures = 0;

    // Reference model state: count value and clean edges since reset.
    int m_bin = 0;
    int m_cyc = 0;

    logic [6:0] font [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always #5 clk = ~clk;

    gray_counter_display #(.DWELL(DWELL)) dut (
        .clk        (clk),
        .reset      (reset),
        .up_pulse   (up_pulse),
        .down_pulse (down_pulse),
        .bin        (bin),
        .gray       (gray),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; model and DUT compared #1 after the edge.
    task automatic step(input logic rst_i, input logic up_i, input logic dn_i);
        int         idx;
        int         b;
        int         g;
        int         nib;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        reset      = rst_i;
        up_pulse   = up_i;
        down_pulse = dn_i;
        b   = m_bin;
        g   = b ^ (b >> 1);
        idx = (m_cyc / DWELL) % 4;
        @(posedge clk);
        #1;
        if (rst_i) begin
            m_bin   = 0;
            m_cyc   = 0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
        end else begin
            case (idx)
                0:       nib = b % 16;
                1:       nib = b / 16;
                2:       nib = g % 16;
                default: nib = g / 16;
            endcase
            exp_an  = 4'b1111;
            exp_an[idx] = 1'b0;
            exp_seg = font[nib];
            exp_dp  = (idx == 2) ? 1'b0 : 1'b1;
            if (up_i && !dn_i) begin
`ifdef GRAY_COUNTER_SATURATE_EN
                if (m_bin < 255) m_bin = m_bin + 1;
`else
                m_bin = (m_bin + 1) % 256;
`endif
            end else if (dn_i && !up_i) begin
`ifdef GRAY_COUNTER_SATURATE_EN
                if (m_bin > 0) m_bin = m_bin - 1;
`else
                m_bin = (m_bin + 255) % 256;
`endif
            end
            m_cyc++;
        end
        check("bin",  32'(bin),  32'(m_bin));
        check("gray", 32'(gray), 32'(m_bin ^ (m_bin >> 1)));
        check("an",   32'(an),   32'(exp_an));
        check("seg",  32'(seg),  32'(exp_seg));
        check("dp",   32'(dp),   32'(exp_dp));
    endtask

    initial begin
        logic [7:0] prev_gray;
        logic [3:0] an_seen;

        // Reset held three cycles, then first edge after release.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_seg", 32'(seg), 32'h0000007F);
        step(1'b0, 1'b0, 1'b0);
        check("rel_an", 32'(an), 32'h0000000E);
        check("rel_seg", 32'(seg), 32'h00000040);

        // Three separated up pulses.
        repeat (3) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("up3_bin", 32'(bin), 32'h03);
        check("up3_gray", 32'(gray), 32'h02);

        // Down from zero.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
`ifdef GRAY_COUNTER_SATURATE_EN
        check("dn0_bin", 32'(bin), 32'h00);
        check("dn0_gray", 32'(gray), 32'h00);
`else
        check("dn0_bin", 32'(bin), 32'hFF);
        check("dn0_gray", 32'(gray), 32'h80);
`endif

        // Both pulses held at 0x10, then up alone for five cycles.
        step(1'b1, 1'b0, 1'b0);
        repeat (16) step(1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 1'b1);
        check("both_bin", 32'(bin), 32'h10);
        repeat (5) step(1'b0, 1'b1, 1'b0);
        check("up5_bin", 32'(bin), 32'h15);

        // 256 consecutive ups: one-bit Gray steps, back to start (or pinned at FF).
        step(1'b1, 1'b0, 1'b0);
        prev_gray = gray;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (gray != prev_gray) check("gray_hd", 32'($countones(gray ^ prev_gray)), 32'd1);
            prev_gray = gray;
        end
`ifdef GRAY_COUNTER_SATURATE_EN
        check("wrap_bin", 32'(bin), 32'hFF);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check("sat_hi_bin", 32'(bin), 32'hFF);
`else
        check("wrap_bin", 32'(bin), 32'h00);
`endif

        // Load 0x5A and watch a full scan.
        step(1'b1, 1'b0, 1'b0);
        repeat (90) step(1'b0, 1'b1, 1'b0);
        check("5a_bin", 32'(bin), 32'h5A);
        while ((m_cyc % (4 * DWELL)) != 0) step(1'b0, 1'b0, 1'b0);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < DWELL; c++) begin
                step(1'b0, 1'b0, 1'b0);
                an_seen = 4'b1111;
                an_seen[d] = 1'b0;
                check("scan_an", 32'(an), 32'(an_seen));
            end
        end

        // Reset in the middle of digit 2.
        while (!(((m_cyc / DWELL) % 4) == 2 && (m_cyc % DWELL) == 1)) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("mid_dp", 32'(dp), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("mid_rst_an", 32'(an), 32'h0000000E);

        // Randomized pulses with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
